// File: rtl/jtsdram_seq.sv
// SDRAM tester top-level sequencer.
// Runs program -> settle -> vsync-aligned check passes, latches per-bank
// failures, counts passes and stops any phase that overruns the watchdog.
module jtsdram_seq #(
  parameter int SETTLE = 16,
  parameter int TOUT_W = 24,
  parameter int LOOPS  = 0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        run,
  input  logic        LVBL,
  output logic        prog_start,
  input  logic        prog_done,
  output logic        chk_start,
  input  logic [3:0]  chk_done,
  input  logic [3:0]  chk_bad,
  output logic        busy,
  output logic [3:0]  bad,
  output logic        timeout,
  output logic [15:0] passes,
  output logic [2:0]  st
);

  localparam logic [2:0] IDLE   = 3'd0;
  localparam logic [2:0] PROG   = 3'd1;
  localparam logic [2:0] PWAIT  = 3'd2;
  localparam logic [2:0] SETTLE_ST = 3'd3;
  localparam logic [2:0] VSYNC  = 3'd4;
  localparam logic [2:0] CWAIT  = 3'd5;
  localparam logic [2:0] NEXT   = 3'd6;

  localparam int SW = (SETTLE < 2) ? 1 : $clog2(SETTLE + 1);
  localparam logic [SW-1:0]     SETTLE_LOAD = SW'(SETTLE - 1);
  // The phase expires on the cycle the counter would step onto all ones.
  localparam logic [TOUT_W-1:0] WD_LAST = {{(TOUT_W-1){1'b1}}, 1'b0};

  logic              lvbl_q;
  logic              lvbl_edge;
  logic              armed;
  logic [TOUT_W-1:0] wdog;
  logic [SW-1:0]     settle_cnt;
  logic              wd_on;
  logic              wd_hit;
  logic [15:0]       passes_inc;
  logic              loop_end;

  assign lvbl_edge  = LVBL & ~lvbl_q;
  assign wd_on      = (st == PWAIT) || (st == VSYNC) || (st == CWAIT);
  assign wd_hit     = wd_on && (wdog == WD_LAST);
  assign passes_inc = (passes == 16'hFFFF) ? passes : passes + 16'd1;
  assign loop_end   = (LOOPS != 0) && (passes_inc == 16'(LOOPS));

  assign prog_start = (st == PROG);
  // Timeout wins over a coincident LVBL edge, so no start pulse then.
  assign chk_start  = (st == VSYNC) && lvbl_edge && !wd_hit;
  assign busy       = (st != IDLE);

  // Registered copy of LVBL for rising-edge detection.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) lvbl_q <= 1'b0;
    else     lvbl_q <= LVBL;
  end

  // Sequencer state, watchdog, settle timer and result bookkeeping.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      st         <= IDLE;
      armed      <= 1'b1;
      wdog       <= '0;
      settle_cnt <= '0;
      bad        <= 4'h0;
      timeout    <= 1'b0;
      passes     <= 16'd0;
    end else begin
      if (wd_on) wdog <= wdog + 1'b1;
      case (st)
        IDLE: begin
          if (!run) begin
            armed <= 1'b1;
          end else if (armed) begin
            armed   <= 1'b0;
            bad     <= 4'h0;
            timeout <= 1'b0;
            passes  <= 16'd0;
            st      <= PROG;
          end
        end
        PROG: begin
          wdog <= '0;
          st   <= PWAIT;
        end
        PWAIT: begin
          // wdog is 0 only in the first PWAIT cycle, where a stale done is ignored.
          if (wd_hit) begin
            timeout <= 1'b1;
            st      <= IDLE;
          end else if (prog_done && (wdog != '0)) begin
            settle_cnt <= SETTLE_LOAD;
            st         <= SETTLE_ST;
          end
        end
        SETTLE_ST: begin
          if (settle_cnt == '0) begin
            wdog <= '0;
            st   <= VSYNC;
          end else begin
            settle_cnt <= settle_cnt - 1'b1;
          end
        end
        VSYNC: begin
          if (wd_hit) begin
            timeout <= 1'b1;
            st      <= IDLE;
          end else if (lvbl_edge) begin
            wdog <= '0;
            st   <= CWAIT;
          end
        end
        CWAIT: begin
          if (wd_hit) begin
            timeout <= 1'b1;
            st      <= IDLE;
          end else if (chk_done == 4'hF) begin
            bad <= bad | chk_bad;
            st  <= NEXT;
          end
        end
        NEXT: begin
          passes <= passes_inc;
          st     <= (!run || loop_end) ? IDLE : PROG;
        end
        default: st <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_jtsdram_seq.sv
// Directed bench for jtsdram_seq (SETTLE=4, TOUT_W=8, LOOPS=3).
module tb_jtsdram_seq;

  logic        clk = 1'b0;
  logic        rst;
  logic        run;
  logic        LVBL;
  logic        prog_start;
  logic        prog_done;
  logic        chk_start;
  logic [3:0]  chk_done;
  logic [3:0]  chk_bad;
  logic        busy;
  logic [3:0]  bad;
  logic        timeout;
  logic [15:0] passes;
  logic [2:0]  st;

  int n_vec = 0;
  int n_bad = 0;
  int n_ps  = 0;

  jtsdram_seq #(.SETTLE(4), .TOUT_W(8), .LOOPS(3)) dut (
    .clk(clk), .rst(rst), .run(run), .LVBL(LVBL),
    .prog_start(prog_start), .prog_done(prog_done),
    .chk_start(chk_start), .chk_done(chk_done), .chk_bad(chk_bad),
    .busy(busy), .bad(bad), .timeout(timeout), .passes(passes), .st(st)
  );

  always #5 clk = ~clk;

  // Count programmer start pulses, sampled mid low phase.
  always @(negedge clk) if (prog_start) n_ps <= n_ps + 1;

  initial begin
    #200000;
    $display("FAIL global_timeout: got no finish, want finish");
    $fatal(1);
  end

  typedef struct {
    logic       run;
    logic       pd;
    logic       lv;
    logic [3:0] cd;
    logic [3:0] cb;
    logic [2:0] st;
    logic       ps;
    logic       cs;
    logic       bz;
    logic [3:0] bd;
    logic [15:0] pa;
  } vec_t;

  vec_t tbl[14];

  function automatic vec_t mk(input logic r, input logic pd, input logic lv,
                              input logic [3:0] cd, input logic [3:0] cb,
                              input logic [2:0] s, input logic ps, input logic cs,
                              input logic bz, input logic [3:0] bd, input logic [15:0] pa);
    vec_t v;
    v.run = r; v.pd = pd; v.lv = lv; v.cd = cd; v.cb = cb;
    v.st = s; v.ps = ps; v.cs = cs; v.bz = bz; v.bd = bd; v.pa = pa;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, want %0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  // One full pass starting in the PROG cycle, ending in the NEXT cycle.
  task automatic do_pass(input int pd, input int ld, input int cd, input logic [3:0] bv,
                         input logic drop, input logic [3:0] bad0, input logic [15:0] pass0);
    int n;
    chk("pass_st_prog", 32'(st), 32'd1);
    chk("pass_prog_start", 32'(prog_start), 32'd1);
    chk("pass_bad_hold", 32'(bad), 32'(bad0));
    chk("pass_count_hold", 32'(passes), 32'(pass0));
    repeat (pd) tick();
    prog_done = 1'b1;
    n = 0;
    while (st != 3'd3 && n < 4) begin tick(); n++; end
    chk("pass_reach_settle", 32'(st), 32'd3);
    prog_done = 1'b0;
    LVBL = 1'b0;
    repeat (3) tick();
    chk("settle_len_a", 32'(st), 32'd3);
    tick();
    chk("settle_len_b", 32'(st), 32'd4);
    repeat (ld) tick();
    #1;
    chk("vsync_wait", 32'(st), 32'd4);
    chk("vsync_no_start", 32'(chk_start), 32'd0);
    LVBL = 1'b1;
    #1;
    chk("chk_start_edge", 32'(chk_start), 32'd1);
    tick();
    chk("cwait_entry", 32'(st), 32'd5);
    chk("chk_start_once", 32'(chk_start), 32'd0);
    if (drop) run = 1'b0;
    chk_done = 4'b1110;
    chk_bad  = 4'hF;
    repeat (cd - 1) tick();
    #1;
    chk("cwait_partial", 32'(st), 32'd5);
    chk_done = 4'hF;
    chk_bad  = bv;
    tick();
    chk_done = 4'h0;
    chk_bad  = 4'h0;
    chk("next_st", 32'(st), 32'd6);
    chk("next_bad", 32'(bad), 32'(bad0 | bv));
    chk("next_passes", 32'(passes), 32'(pass0));
  endtask

  initial begin
    int n;
    //               run   pd    lv    cd     cb     st    ps    cs    bz    bad    passes
    tbl[0]  = mk(1'b0, 1'b0, 1'b1, 4'h0, 4'h0, 3'd0, 1'b0, 1'b0, 1'b0, 4'h0, 16'd0);
    tbl[1]  = mk(1'b1, 1'b0, 1'b1, 4'h0, 4'h0, 3'd0, 1'b0, 1'b0, 1'b0, 4'h0, 16'd0);
    tbl[2]  = mk(1'b1, 1'b0, 1'b1, 4'h0, 4'h0, 3'd1, 1'b1, 1'b0, 1'b1, 4'h0, 16'd0);
    tbl[3]  = mk(1'b1, 1'b1, 1'b1, 4'h0, 4'h0, 3'd2, 1'b0, 1'b0, 1'b1, 4'h0, 16'd0);
    tbl[4]  = mk(1'b1, 1'b1, 1'b1, 4'h0, 4'h0, 3'd2, 1'b0, 1'b0, 1'b1, 4'h0, 16'd0);
    tbl[5]  = mk(1'b1, 1'b0, 1'b0, 4'h0, 4'h0, 3'd3, 1'b0, 1'b0, 1'b1, 4'h0, 16'd0);
    tbl[6]  = mk(1'b1, 1'b0, 1'b0, 4'h0, 4'h0, 3'd3, 1'b0, 1'b0, 1'b1, 4'h0, 16'd0);
    tbl[7]  = mk(1'b1, 1'b0, 1'b0, 4'h0, 4'h0, 3'd3, 1'b0, 1'b0, 1'b1, 4'h0, 16'd0);
    tbl[8]  = mk(1'b1, 1'b0, 1'b0, 4'h0, 4'h0, 3'd3, 1'b0, 1'b0, 1'b1, 4'h0, 16'd0);
    tbl[9]  = mk(1'b1, 1'b0, 1'b0, 4'h0, 4'h0, 3'd4, 1'b0, 1'b0, 1'b1, 4'h0, 16'd0);
    tbl[10] = mk(1'b1, 1'b0, 1'b1, 4'h0, 4'h0, 3'd4, 1'b0, 1'b1, 1'b1, 4'h0, 16'd0);
    tbl[11] = mk(1'b1, 1'b0, 1'b1, 4'h5, 4'h4, 3'd5, 1'b0, 1'b0, 1'b1, 4'h0, 16'd0);
    tbl[12] = mk(1'b1, 1'b0, 1'b1, 4'hF, 4'h4, 3'd5, 1'b0, 1'b0, 1'b1, 4'h0, 16'd0);
    tbl[13] = mk(1'b1, 1'b0, 1'b1, 4'h0, 4'h0, 3'd6, 1'b0, 1'b0, 1'b1, 4'h4, 16'd0);

    rst = 1'b1; run = 1'b0; LVBL = 1'b1; prog_done = 1'b0;
    chk_done = 4'h0; chk_bad = 4'h0;
    repeat (3) @(negedge clk);
    chk("rst_st", 32'(st), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_prog_start", 32'(prog_start), 32'd0);
    chk("rst_chk_start", 32'(chk_start), 32'd0);
    chk("rst_bad", 32'(bad), 32'd0);
    chk("rst_timeout", 32'(timeout), 32'd0);
    chk("rst_passes", 32'(passes), 32'd0);
    rst = 1'b0;

    // Pass 1 cycle by cycle, stale prog_done and partial chk_done included.
    for (int i = 0; i < 14; i++) begin
      run = tbl[i].run; prog_done = tbl[i].pd; LVBL = tbl[i].lv;
      chk_done = tbl[i].cd; chk_bad = tbl[i].cb;
      #1;
      chk($sformatf("row%0d_st", i), 32'(st), 32'(tbl[i].st));
      chk($sformatf("row%0d_prog_start", i), 32'(prog_start), 32'(tbl[i].ps));
      chk($sformatf("row%0d_chk_start", i), 32'(chk_start), 32'(tbl[i].cs));
      chk($sformatf("row%0d_busy", i), 32'(busy), 32'(tbl[i].bz));
      chk($sformatf("row%0d_bad", i), 32'(bad), 32'(tbl[i].bd));
      chk($sformatf("row%0d_passes", i), 32'(passes), 32'(tbl[i].pa));
      chk($sformatf("row%0d_timeout", i), 32'(timeout), 32'd0);
      tick();
    end
    chk_done = 4'h0; chk_bad = 4'h0;

    // Passes 2 and 3 with nominal timing; LOOPS=3 then parks in IDLE.
    do_pass(100, 20, 50, 4'b0001, 1'b0, 4'b0100, 16'd1);
    tick();
    do_pass(100, 20, 50, 4'b0000, 1'b0, 4'b0101, 16'd2);
    tick();
    chk("loops_st", 32'(st), 32'd0);
    chk("loops_busy", 32'(busy), 32'd0);
    chk("loops_passes", 32'(passes), 32'd3);
    chk("loops_bad", 32'(bad), 32'd5);
    repeat (20) tick();
    #1;
    chk("loops_idle_hold", 32'(st), 32'd0);
    chk("loops_prog_pulses", 32'(n_ps), 32'd3);

    // Stop request during CWAIT: pass completes, then IDLE.
    run = 1'b0; tick();
    run = 1'b1; tick();
    do_pass(30, 5, 10, 4'b0000, 1'b1, 4'b0000, 16'd0);
    tick();
    chk("stop_st", 32'(st), 32'd0);
    chk("stop_passes", 32'(passes), 32'd1);
    repeat (10) tick();
    #1;
    chk("stop_no_prog", 32'(n_ps), 32'd4);

    // Watchdog expiry in PWAIT, then restart via run toggle.
    run = 1'b1; tick();
    chk("to_prog", 32'(prog_start), 32'd1);
    tick();
    chk("to_pwait_entry", 32'(st), 32'd2);
    repeat (254) tick();
    chk("to_before_st", 32'(st), 32'd2);
    chk("to_before_flag", 32'(timeout), 32'd0);
    tick();
    chk("to_st", 32'(st), 32'd0);
    chk("to_flag", 32'(timeout), 32'd1);
    repeat (10) tick();
    chk("to_no_restart", 32'(st), 32'd0);
    chk("to_sticky", 32'(timeout), 32'd1);
    run = 1'b0; tick();
    run = 1'b1; tick();
    chk("to_restart_st", 32'(st), 32'd1);
    chk("to_restart_clear", 32'(timeout), 32'd0);

    // Fill sticky state, walk into CWAIT, then reset asynchronously.
    do_pass(10, 3, 3, 4'b1000, 1'b0, 4'b0000, 16'd0);
    tick();
    n = 0;
    while (st != 3'd5 && n < 40) begin
      prog_done = (st == 3'd2);
      LVBL = (st == 3'd4);
      tick();
      n++;
    end
    prog_done = 1'b0;
    chk("rstm_in_cwait", 32'(st), 32'd5);
    chk("rstm_bad_before", 32'(bad), 32'd8);
    chk("rstm_passes_before", 32'(passes), 32'd1);
    #2 rst = 1'b1;
    #1;
    chk("rstm_st", 32'(st), 32'd0);
    chk("rstm_busy", 32'(busy), 32'd0);
    chk("rstm_bad", 32'(bad), 32'd0);
    chk("rstm_passes", 32'(passes), 32'd0);
    chk("rstm_timeout", 32'(timeout), 32'd0);
    chk("rstm_prog_start", 32'(prog_start), 32'd0);
    chk("rstm_chk_start", 32'(chk_start), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    n = 0;
    while (!prog_start && n < 2) begin tick(); n++; end
    chk("rstm_restart", 32'(prog_start), 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/jtsdram_seq.md
Name: jtsdram_seq

Overview:
- Top-level test sequencer for the SDRAM tester.
- Pulses the programming block's start, waits for it to finish, waits a settle interval, then starts the four per-bank read-back checkers together and collects their done/bad results.
- Counts passes, latches sticky per-bank failures and enforces a watchdog timeout on every phase.
- Sits between the board control inputs (run/stop) and the programmer/checker instances.

Parameters:
- SETTLE, 16, clock cycles spent in SETTLE between programming done and checker start (≥1).
- TOUT_W, 24, watchdog counter width; a phase times out when the counter saturates at all ones.
- LOOPS, 0, number of passes to run; 0 means run forever until run is deasserted.

Ports:
- clk  input  1  system clock
- rst  input  1  asynchronous active-high reset
- run  input  1  level; 1 = run test loop, 0 = stop at next pass boundary
- LVBL  input  1  active-low vertical blank; checker start is aligned to its rising edge
- prog_start  output  1  one-cycle pulse to the programmer
- prog_done  input  1  programmer finished (level)
- chk_start  output  1  one-cycle pulse to all four bank checkers
- chk_done  input  4  per-bank checker finished (level)
- chk_bad  input  4  per-bank mismatch flag, valid while the matching chk_done is 1
- busy  output  1  1 whenever state ≠ IDLE
- bad  output  4  sticky per-bank failure
- timeout  output  1  sticky watchdog expiry
- passes  output  16  completed passes; saturates at 16'hFFFF
- st  output  3  current state encoding, for debug

Behaviour:
- Reset values: prog_start=0, chk_start=0, busy=0, bad=0, timeout=0, passes=0, st=IDLE, watchdog=0, settle counter=0.
- State encodings: IDLE=0, PROG=1, PWAIT=2, SETTLE=3, VSYNC=4, CWAIT=5, NEXT=6.
- IDLE: if run=1, go to PROG. Entering PROG from IDLE clears bad, timeout and passes.
- PROG: prog_start=1 for exactly this one cycle, watchdog cleared, then go to PWAIT.
- PWAIT: ignore prog_done in the first cycle, because the programmer clears done on start. On prog_done=1 go to SETTLE with the settle counter loaded with SETTLE-1.
- SETTLE: decrement the counter; when it reaches 0, go to VSYNC.
- VSYNC: wait for a LVBL 0→1 edge, detected against a registered copy of LVBL. On the edge cycle go to CWAIT with chk_start=1 for that one cycle and the watchdog cleared.
- CWAIT: wait until chk_done==4'hF. In that cycle OR chk_bad into bad, then go to NEXT. Individual done bits may arrive in any order; only all-four counts.
- NEXT: passes += 1 unless already saturated. Go to IDLE if run=0, or if LOOPS≠0 and the new passes value equals LOOPS. Otherwise go to PROG.
- Watchdog: increments every cycle in PWAIT, VSYNC and CWAIT, and clears on entry to each of those states. When it reaches all ones, set timeout=1 and go to IDLE. This is a terminal stop: a new run 0→1 is required to restart.
- Restart rule: leaving IDLE requires run=1 and either this is the first run after reset, or run was seen at 0 since the last stop. Track this with an armed flag: set when run=0 in IDLE, cleared on leaving IDLE.
- run deasserted mid-pass does not abort; the current pass completes, and NEXT then returns to IDLE.
- prog_done already high on entry to PWAIT (stale): the one-cycle ignore window covers it. A prog_done still high on the second cycle counts as done.
- Simultaneous LVBL edge and watchdog expiry in VSYNC: timeout has priority; no chk_start is issued.
- Asynchronous reset mid-pass: all outputs return to reset values immediately; the sticky flags are lost.

Test Plan:
- Nominal pass, SETTLE=4:
  - Stimulus: run=1; model prog_done 100 cycles after prog_start; LVBL edge 20 cycles later; chk_done=F, chk_bad=0 after 50 cycles.
  - Required: one prog_start pulse, chk_start on the LVBL edge cycle, passes=1, bad=0, next prog_start one cycle after NEXT.
- Failure latch:
  - Stimulus: pass 1 returns chk_bad=4'b0100; pass 2 returns 4'b0001.
  - Required: bad=4'b0101 after pass 2; bad not cleared between passes.
- LOOPS=3:
  - Stimulus: run held at 1.
  - Required: exactly 3 prog_start pulses, passes=3, busy=0, st=0; no further activity while run stays 1.
- Timeout, TOUT_W=8:
  - Stimulus: never assert prog_done.
  - Required: timeout=1 and st=IDLE 255 cycles after PWAIT entry. Toggling run 1→0→1 restarts and clears timeout.
- Stop request:
  - Stimulus: drop run while in CWAIT.
  - Required: the pass completes, passes increments by 1, then IDLE; no new prog_start.
- Reset mid-CWAIT:
  - Stimulus: assert rst.
  - Required: all outputs return to reset values in the same cycle; after release with run=1, a prog_start follows within 2 cycles.
